// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file completer.
//   apb_state_t    : two-state transfer FSM encoding
//   APB_DEFAULT_ID : default contents of the read-only ID word
//   strb_to_mask   : expands up to 8 byte strobes into a 64-bit lane mask;
//                    callers truncate the result to their data width
package apb_pkg;

  typedef enum logic {
    APB_IDLE   = 1'b0,
    APB_ACCESS = 1'b1
  } apb_state_t;

  localparam logic [31:0] APB_DEFAULT_ID = 32'hA9B5_0001;

  function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
    logic [63:0] mask;
    mask = '0;
    for (int b = 0; b < 8; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// Storage for words 1..DEPTH-1 of the register file (word 0 is the ID word
// and lives in the top level as a constant).
//   clk, rst  : clock, synchronous active-high clear of every stored word
//   we        : write enable for wr_idx
//   wr_idx    : word index to write
//   wmask     : per-bit write mask (byte lanes already expanded)
//   wdata     : write data
//   rd_idx    : word index to read (combinational)
//   rd_data   : stored word, or 0 for index 0 / indices beyond DEPTH-1
module apb_regfile_mem #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 32,
  parameter int MW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [MW-1:0]     wr_idx,
  input  logic [DWIDTH-1:0] wmask,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [MW-1:0]     rd_idx,
  output logic [DWIDTH-1:0] rd_data
);

  localparam logic [MW:0] DEPTH_X = (MW+1)'(DEPTH);

  logic [DWIDTH-1:0] mem_reg [1:DEPTH-1];
  logic [DEPTH-1:1]  word_sel;

  // One-hot write decode per stored word.
  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_sel
      assign word_sel[gi] = we && (wr_idx == MW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (rst) begin
        mem_reg[i] <= '0;
      end else if (word_sel[i]) begin
        mem_reg[i] <= (mem_reg[i] & ~wmask) | (wdata & wmask);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_idx != '0 && {1'b0, rd_idx} < DEPTH_X) begin
      rd_data = mem_reg[rd_idx];
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer in front of a DEPTH-word register file with a read-only
// ID word at index 0, programmable wait states, byte strobes and PSLVERR.
//   clk, rst          : clock, synchronous active-high reset
//   p_sel, p_en       : APB select / enable (SETUP = sel & !en)
//   p_write           : 1 = write, 0 = read
//   addr              : byte address, low log2(DWIDTH/8) bits ignored
//   wdata, p_strb     : write data and byte-lane strobes
//   rdata             : read data, loaded at the read's SETUP edge
//   p_ready, p_slverr : transfer complete / error (error qualified by ready)
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          AWIDTH      = 8,
  parameter int          DWIDTH      = 32,
  parameter int          DEPTH       = 32,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = APB_DEFAULT_ID
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p_sel,
  input  logic                p_en,
  input  logic                p_write,
  input  logic [AWIDTH-1:0]   addr,
  input  logic [DWIDTH-1:0]   wdata,
  input  logic [DWIDTH/8-1:0] p_strb,
  output logic [DWIDTH-1:0]   rdata,
  output logic                p_ready,
  output logic                p_slverr
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int OFS    = $clog2(NBYTES);
  localparam int IW     = AWIDTH - OFS;
  localparam int MW     = $clog2(DEPTH);
  localparam int CW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [IW:0]       DEPTH_X   = (IW+1)'(DEPTH);
  localparam logic [CW-1:0]     WAIT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [DWIDTH-1:0] ID_WORD   = DWIDTH'(ID_VALUE);

  apb_state_t        state_reg, state_next;
  logic [IW-1:0]     idx_reg;
  logic              write_reg;
  logic [CW-1:0]     cnt_reg;
  logic [DWIDTH-1:0] rdata_reg;

  logic [IW-1:0]     setup_idx;
  logic              setup;
  logic              setup_ok;
  logic [DWIDTH-1:0] setup_word;
  logic [DWIDTH-1:0] mem_rdata;
  logic              acc_err;
  logic              mem_we;
  logic [DWIDTH-1:0] wmask;

  // Byte-offset address bits carry no information for word accesses.
  generate
    if (OFS > 0) begin : g_unused_ofs
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr[OFS-1:0];
    end
  endgenerate

  assign setup_idx = addr[AWIDTH-1:OFS];
  assign setup     = (state_reg == APB_IDLE) && p_sel && !p_en;
  // Unsigned compare on the full index so large addresses never alias.
  assign setup_ok  = ({1'b0, setup_idx} < DEPTH_X);

  always_comb begin
    setup_word = '0;
    if (setup_ok) begin
      setup_word = (setup_idx == '0) ? ID_WORD : mem_rdata;
    end
  end

  // Error decode uses only the SETUP-captured index and direction.
  assign acc_err  = !({1'b0, idx_reg} < DEPTH_X) || (write_reg && idx_reg == '0);
  assign p_ready  = (state_reg == APB_ACCESS) && (cnt_reg == '0) && p_sel && p_en;
  assign p_slverr = p_ready && acc_err;
  assign rdata    = rdata_reg;

  assign mem_we = p_ready && write_reg && !acc_err;
  assign wmask  = DWIDTH'(strb_to_mask(8'(p_strb)));

  apb_regfile_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .MW     (MW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .wr_idx  (idx_reg[MW-1:0]),
    .wmask   (wmask),
    .wdata   (wdata),
    .rd_idx  (setup_idx[MW-1:0]),
    .rd_data (mem_rdata)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      APB_IDLE: begin
        if (setup) state_next = APB_ACCESS;
      end
      APB_ACCESS: begin
        // Either normal completion or a master abort (select dropped).
        if (!p_sel || p_ready) state_next = APB_IDLE;
      end
      default: state_next = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= APB_IDLE;
      idx_reg   <= '0;
      write_reg <= 1'b0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (setup) begin
        idx_reg   <= setup_idx;
        write_reg <= p_write;
        cnt_reg   <= WAIT_LOAD;
        if (!p_write) rdata_reg <= setup_word;
      end else if (state_reg == APB_ACCESS && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA9B5_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_sel, p_en, p_write;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  p_strb;
  logic        use3;

  logic        sel0, sel3;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, err0, err3;
  logic [31:0] rdata_m;
  logic        ready_m, err_m;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign sel0    = p_sel & ~use3;
  assign sel3    = p_sel & use3;
  assign rdata_m = use3 ? rdata3 : rdata0;
  assign ready_m = use3 ? ready3 : ready0;
  assign err_m   = use3 ? err3 : err0;

  apb_slave_regfile #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .p_sel(sel0), .p_en(p_en), .p_write(p_write),
    .addr(addr), .wdata(wdata), .p_strb(p_strb),
    .rdata(rdata0), .p_ready(ready0), .p_slverr(err0)
  );

  apb_slave_regfile #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .p_sel(sel3), .p_en(p_en), .p_write(p_write),
    .addr(addr), .wdata(wdata), .p_strb(p_strb),
    .rdata(rdata3), .p_ready(ready3), .p_slverr(err3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One APB transfer. Entered just after a rising edge; returns just after
  // the completing edge with the bus idle so a new SETUP may follow at once.
  // addr and p_write are scrambled during ACCESS to confirm they are ignored.
  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic err,
                          output int acc_cycles, output int ready_cnt);
    p_sel = 1'b1; p_en = 1'b0; p_write = wr; addr = a; wdata = d; p_strb = s;
    rd = '0; err = 1'b0; acc_cycles = 0; ready_cnt = 0;
    @(negedge clk);
    if (ready_m === 1'b1) ready_cnt++;
    @(posedge clk); #1;
    p_en = 1'b1; addr = ~a; p_write = ~wr;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready_m === 1'b1) begin
        ready_cnt++; acc_cycles = n; rd = rdata_m; err = err_m;
      end
      @(posedge clk); #1;
      if (acc_cycles != 0) break;
    end
    p_sel = 1'b0; p_en = 1'b0;
    $display("xfer dut%0d %s addr=%h wdata=%h strb=%h -> rdata=%h err=%0d acc=%0d",
             use3 ? 3 : 0, wr ? "W" : "R", a, d, s, rd, err, acc_cycles);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [19];

  initial begin
    logic [31:0] rd;
    logic        err;
    int          acc, rc;

    tbl[0]  = '{1'b0, 8'h00, 32'h0,         4'h0, ID,            1'b0};
    tbl[1]  = '{1'b1, 8'h14, 32'h1234_5678, 4'hF, ID,            1'b0};
    tbl[2]  = '{1'b0, 8'h14, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    tbl[3]  = '{1'b1, 8'h14, 32'hAABB_CCDD, 4'h5, 32'h1234_5678, 1'b0};
    tbl[4]  = '{1'b0, 8'h14, 32'h0,         4'h0, 32'h12BB_56DD, 1'b0};
    tbl[5]  = '{1'b1, 8'h14, 32'hFFFF_FFFF, 4'h0, 32'h12BB_56DD, 1'b0};
    tbl[6]  = '{1'b0, 8'h14, 32'h0,         4'h0, 32'h12BB_56DD, 1'b0};
    tbl[7]  = '{1'b1, 8'h80, 32'h1111_1111, 4'hF, 32'h12BB_56DD, 1'b1};
    tbl[8]  = '{1'b0, 8'h80, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[9]  = '{1'b1, 8'h00, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b1};
    tbl[10] = '{1'b0, 8'h00, 32'h0,         4'h0, ID,            1'b0};
    tbl[11] = '{1'b0, 8'h7C, 32'h0,         4'h0, 32'h0,         1'b0};
    tbl[12] = '{1'b1, 8'h7C, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    tbl[13] = '{1'b0, 8'h7C, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    tbl[14] = '{1'b1, 8'hFC, 32'h5555_5555, 4'hF, 32'hCAFE_F00D, 1'b1};
    tbl[15] = '{1'b0, 8'h7C, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    tbl[16] = '{1'b1, 8'h17, 32'h0102_0304, 4'hF, 32'hCAFE_F00D, 1'b0};
    tbl[17] = '{1'b0, 8'h14, 32'h0,         4'h0, 32'h0102_0304, 1'b0};
    tbl[18] = '{1'b0, 8'hFC, 32'h0,         4'h0, 32'h0,         1'b1};

    rst = 1'b1; p_sel = 1'b0; p_en = 1'b0; p_write = 1'b0;
    addr = '0; wdata = '0; p_strb = '0; use3 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", {31'b0, ready0}, 32'h0);
    check("rst_err0",   {31'b0, err0},   32'h0);
    check("rst_rdata0", rdata0,          32'h0);
    check("rst_ready3", {31'b0, ready3}, 32'h0);
    check("rst_err3",   {31'b0, err3},   32'h0);
    check("rst_rdata3", rdata3,          32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven transfers, zero wait states
    for (int i = 0; i < 19; i++) begin
      apb_xfer(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, rd, err, acc, rc);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
      check($sformatf("tbl%0d_acc", i), acc, 1);
      check($sformatf("tbl%0d_readycnt", i), rc, 1);
    end

    // Back-to-back writes then reads, no idle cycles
    for (int i = 0; i < 10; i++) begin
      apb_xfer(1'b1, 8'(4*i), 32'(2*i), 4'hF, rd, err, acc, rc);
      check($sformatf("b2b_w%0d_err", i), {31'b0, err}, (i == 0) ? 32'h1 : 32'h0);
      check($sformatf("b2b_w%0d_acc", i), acc, 1);
      check($sformatf("b2b_w%0d_readycnt", i), rc, 1);
    end
    for (int i = 0; i < 10; i++) begin
      apb_xfer(1'b0, 8'(4*i), 32'h0, 4'h0, rd, err, acc, rc);
      check($sformatf("b2b_r%0d_rdata", i), rd, (i == 0) ? ID : 32'(2*i));
      check($sformatf("b2b_r%0d_err", i), {31'b0, err}, 32'h0);
      check($sformatf("b2b_r%0d_acc", i), acc, 1);
    end

    // Master abort on a write to 0x30
    apb_xfer(1'b1, 8'h30, 32'h0BAD_F00D, 4'hF, rd, err, acc, rc);
    check("abort_prewrite_acc", acc, 1);
    p_sel = 1'b1; p_en = 1'b0; p_write = 1'b1; addr = 8'h30;
    wdata = 32'hFFFF_FFFF; p_strb = 4'hF;
    @(posedge clk); #1;
    p_sel = 1'b0; p_en = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'b0, ready0}, 32'h0);
    @(posedge clk); #1;
    p_en = 1'b0;
    $display("xfer dut0 W addr=30 aborted");
    apb_xfer(1'b0, 8'h30, 32'h0, 4'h0, rd, err, acc, rc);
    check("abort_readback", rd, 32'h0BAD_F00D);

    // Three wait states
    use3 = 1'b1;
    apb_xfer(1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, rd, err, acc, rc);
    check("ws_w_acc", acc, 4);
    check("ws_w_readycnt", rc, 1);
    check("ws_w_err", {31'b0, err}, 32'h0);
    apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, err, acc, rc);
    check("ws_r_rdata", rd, 32'hDEAD_BEEF);
    check("ws_r_acc", acc, 4);
    check("ws_r_readycnt", rc, 1);

    // Reset during the 2nd ACCESS cycle of a wait-state write
    rc = 0;
    p_sel = 1'b1; p_en = 1'b0; p_write = 1'b1; addr = 8'h08;
    wdata = 32'd55; p_strb = 4'hF;
    @(posedge clk); #1;
    p_en = 1'b1;
    @(negedge clk);
    if (ready3 === 1'b1) rc++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    if (ready3 === 1'b1) rc++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ready3 === 1'b1) rc++;
      @(posedge clk); #1;
    end
    p_sel = 1'b0; p_en = 1'b0;
    $display("xfer dut3 W addr=08 interrupted by reset");
    check("midrst_readycnt", rc, 0);
    apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, err, acc, rc);
    check("midrst_readback", rd, 32'h0);
    check("midrst_acc", acc, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
